// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with waitrequest stalls,
// bus timeout and retired-instruction counting. Optional illegal-opcode trap: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
module multicycle_control #(
    parameter int ALUOP_W     = 6,
    parameter int TIMEOUT_W   = 8,
    parameter int TIMEOUT_MAX = 255,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         func_code,
    input  logic               rs_eq_rt,
    input  logic               mem_waitreq,
    output logic               instr_read,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               alu_src,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               halt,
    output logic               bus_err,
    output logic [CNT_W-1:0]   retired,
    output logic               illegal
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALTED = 3'd6;

    localparam logic [5:0] OP_HALT = 6'h3F;
    localparam logic                 TMO_EN   = (TIMEOUT_MAX != 0);
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_MAX - 1);

    logic [2:0]           state_q, state_d;
    logic [5:0]           op_q, op_d, fn_q, fn_d;
    logic [TIMEOUT_W-1:0] tcnt_q, tcnt_d;
    logic [CNT_W-1:0]     retired_q, retired_d;
    logic                 bus_err_q, bus_err_d;
    logic                 tmo_hit_s, trap_s;
    logic                 is_addu_s, is_jr_s, is_addiu_s, is_lw_s, is_sw_s, is_beq_s, is_bne_s, is_j_s;
    logic [ALUOP_W+5:0]   op_ext_s;

    assign is_addu_s  = (op_q == 6'h00) && (fn_q == 6'h21);
    assign is_jr_s    = (op_q == 6'h00) && (fn_q == 6'h08);
    assign is_addiu_s = (op_q == 6'h09);
    assign is_lw_s    = (op_q == 6'h23);
    assign is_sw_s    = (op_q == 6'h2B);
    assign is_beq_s   = (op_q == 6'h04);
    assign is_bne_s   = (op_q == 6'h05);
    assign is_j_s     = (op_q == 6'h02);
    assign tmo_hit_s  = TMO_EN && mem_waitreq && (tcnt_q == TMO_LAST);
    assign op_ext_s   = {{ALUOP_W{1'b0}}, op_q};

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    function automatic logic is_listed(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00:   is_listed = (fn == 6'h21) || (fn == 6'h08);
            6'h09, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F: is_listed = 1'b1;
            default: is_listed = 1'b0;
        endcase
    endfunction

    assign trap_s = !is_listed(opcode, func_code);

    // Sticky illegal flag, raised only when DECODE actually takes the trap path
    always_comb begin
        illegal_d = illegal_q;
        if ((state_q == S_DECODE) && trap_s) begin
            illegal_d = 1'b1;
        end else begin
            illegal_d = illegal_q;
        end
    end

    // Illegal flag register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) illegal_q <= 1'b0;
        else          illegal_q <= illegal_d;
    end

    assign illegal = illegal_q;
`else
    assign trap_s  = 1'b0;
    assign illegal = 1'b0;
`endif

    // Next-state, instruction latch, timeout and retire bookkeeping
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        fn_d      = fn_q;
        bus_err_d = bus_err_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (!mem_waitreq) begin
                    state_d = S_DECODE;
                end else if (tmo_hit_s) begin
                    state_d   = S_HALTED;
                    bus_err_d = 1'b1;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                op_d = opcode;
                fn_d = func_code;
                if (opcode == OP_HALT)  state_d = S_HALTED;
                else if (trap_s)        state_d = S_HALTED;
                else                    state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_addu_s || is_addiu_s)  state_d = S_WB;
                else if (is_lw_s || is_sw_s)  state_d = S_MEM;
                else                          state_d = S_FETCH;
            end
            S_MEM: begin
                if (!mem_waitreq) begin
                    state_d = is_lw_s ? S_WB : S_FETCH;
                end else if (tmo_hit_s) begin
                    state_d   = S_HALTED;
                    bus_err_d = 1'b1;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB:     state_d = S_FETCH;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase

        // Wait counter restarts on every new bus access
        if (((state_d == S_FETCH) || (state_d == S_MEM)) && (state_d != state_q)) begin
            tcnt_d = {TIMEOUT_W{1'b0}};
        end else if (((state_q == S_FETCH) || (state_q == S_MEM)) && mem_waitreq) begin
            tcnt_d = tcnt_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
        end else begin
            tcnt_d = tcnt_q;
        end

        if ((state_d == S_FETCH) &&
            ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB))) begin
            retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            retired_d = retired_q;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            op_q      <= 6'h00;
            fn_q      <= 6'h00;
            tcnt_q    <= {TIMEOUT_W{1'b0}};
            retired_q <= {CNT_W{1'b0}};
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            fn_q      <= fn_d;
            tcnt_q    <= tcnt_d;
            retired_q <= retired_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Strobes decode straight from state so reset clears them without waiting for a clock
    always_comb begin
        instr_read = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        halt       = 1'b0;
        alu_op     = op_ext_s[ALUOP_W-1:0];
        case (state_q)
            S_IDLE:   alu_op = {ALUOP_W{1'b0}};
            S_FETCH: begin
                alu_op     = {ALUOP_W{1'b0}};
                instr_read = 1'b1;
                ir_write   = !mem_waitreq;
                pc_write   = !mem_waitreq;
            end
            S_DECODE: halt = 1'b0;
            S_EXEC: begin
                reg_dst = is_addu_s;
                alu_src = is_addiu_s || is_lw_s || is_sw_s;
                if (is_jr_s) begin
                    pc_write = 1'b1;
                    pc_src   = 2'b10;
                end else if (is_beq_s || is_bne_s) begin
                    pc_write = is_beq_s ? rs_eq_rt : !rs_eq_rt;
                    pc_src   = 2'b01;
                end else if (is_j_s) begin
                    pc_write = 1'b1;
                    pc_src   = 2'b11;
                end else begin
                    pc_write = 1'b0;
                end
            end
            S_MEM: begin
                mem_read  = is_lw_s;
                mem_write = is_sw_s;
                alu_src   = 1'b1;
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_lw_s;
                reg_dst    = is_addu_s;
            end
            S_HALTED: begin
                alu_op = {ALUOP_W{1'b0}};
                halt   = 1'b1;
            end
            default:  alu_op = {ALUOP_W{1'b0}};
        endcase
    end

    assign bus_err = bus_err_q;
    assign retired = retired_q;
endmodule
